// File: rtl/gat_bram_loader.sv
// rtl/gat_bram_loader.sv - splits one word stream into the H data, node-info and weight BRAM write ports
// Registered write ports, one word per accepted beat; framing is checked against the fixed phase lengths.
module gat_bram_loader #(
    parameter int TOP_WIDTH         = 32,
    parameter int H_NUM_SPARSE_DATA = 242101,
    parameter int TOTAL_NODES       = 13264,
    parameter int NUM_FEATURE_IN    = 1433,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int H_DATA_ADDR_W     = $clog2(H_NUM_SPARSE_DATA),
    parameter int NODE_INFO_ADDR_W  = $clog2(TOTAL_NODES),
    parameter int WEIGHT_ADDR_W     = $clog2(NUM_FEATURE_IN * NUM_FEATURE_OUT)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          load_start_i,
    input  logic [TOP_WIDTH-1:0]          s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic                          s_last_i,
    output logic [TOP_WIDTH-1:0]          h_data_bram_din_o,
    output logic                          h_data_bram_ena_o,
    output logic                          h_data_bram_wea_o,
    output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra_o,
    output logic [TOP_WIDTH-1:0]          h_node_info_bram_din_o,
    output logic                          h_node_info_bram_ena_o,
    output logic                          h_node_info_bram_wea_o,
    output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra_o,
    output logic [TOP_WIDTH-1:0]          wgt_bram_din_o,
    output logic                          wgt_bram_ena_o,
    output logic                          wgt_bram_wea_o,
    output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra_o,
    output logic                          h_data_bram_load_done_o,
    output logic                          h_node_info_bram_load_done_o,
    output logic                          wgt_bram_load_done_o,
    output logic                          load_busy_o,
    output logic                          load_error_o
);

    localparam int W_WORDS = NUM_FEATURE_IN * NUM_FEATURE_OUT;
    localparam int CNT_W0  = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W : NODE_INFO_ADDR_W;
    localparam int CNT_W   = (CNT_W0 > WEIGHT_ADDR_W) ? CNT_W0 : WEIGHT_ADDR_W;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_NUM_SPARSE_DATA - 1);
    localparam logic [CNT_W-1:0] NI_LAST = CNT_W'(TOTAL_NODES - 1);
    localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(W_WORDS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD_H  = 2'd1;
    localparam logic [1:0] S_LOAD_NI = 2'd2;
    localparam logic [1:0] S_LOAD_W  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic phase_last;
    logic final_word;
    logic abort;
    logic frame_err;
    logic start_clr;
    logic h_wr, ni_wr, w_wr;

    logic                        h_we_q, ni_we_q, w_we_q;
    logic [TOP_WIDTH-1:0]        h_din_q, ni_din_q, w_din_q;
    logic [H_DATA_ADDR_W+1:0]    h_addr_q;
    logic [NODE_INFO_ADDR_W+1:0] ni_addr_q;
    logic [WEIGHT_ADDR_W+1:0]    w_addr_q;

    logic h_pend_q, ni_pend_q, w_pend_q;
    logic h_pend_d, ni_pend_d, w_pend_d;
    logic h_done_q, ni_done_q, w_done_q;
    logic err_q;

    assign s_ready_o   = (state_q != S_IDLE);
    assign load_busy_o = (state_q != S_IDLE);
    assign accept      = s_valid_i & s_ready_o;
    assign start_clr   = (state_q == S_IDLE) & load_start_i;

    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            S_LOAD_H:  phase_last = (cnt_q == H_LAST);
            S_LOAD_NI: phase_last = (cnt_q == NI_LAST);
            S_LOAD_W:  phase_last = (cnt_q == W_LAST);
            default:   phase_last = 1'b0;
        endcase
    end

    // Only the final weight word may carry s_last, and it must.
    assign final_word = (state_q == S_LOAD_W) & phase_last;
    assign abort      = accept & s_last_i & ~final_word;
    assign frame_err  = abort | (accept & final_word & ~s_last_i);

    assign h_wr  = accept & (state_q == S_LOAD_H);
    assign ni_wr = accept & (state_q == S_LOAD_NI);
    assign w_wr  = accept & (state_q == S_LOAD_W);

    assign h_pend_d  = h_wr & phase_last & ~abort;
    assign ni_pend_d = ni_wr & phase_last & ~abort;
    assign w_pend_d  = w_wr & phase_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (load_start_i) begin
                state_d = S_LOAD_H;
                cnt_d   = '0;
            end
        end else if (accept) begin
            if (abort) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (phase_last) begin
                cnt_d = '0;
                case (state_q)
                    S_LOAD_H:  state_d = S_LOAD_NI;
                    S_LOAD_NI: state_d = S_LOAD_W;
                    default:   state_d = S_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write ports: enables pulse for one cycle, data/address hold between writes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_we_q    <= 1'b0;
            ni_we_q   <= 1'b0;
            w_we_q    <= 1'b0;
            h_din_q   <= '0;
            ni_din_q  <= '0;
            w_din_q   <= '0;
            h_addr_q  <= '0;
            ni_addr_q <= '0;
            w_addr_q  <= '0;
        end else begin
            h_we_q  <= h_wr;
            ni_we_q <= ni_wr;
            w_we_q  <= w_wr;
            if (h_wr) begin
                h_din_q  <= s_data_i;
                h_addr_q <= {cnt_q[H_DATA_ADDR_W-1:0], 2'b00};
            end
            if (ni_wr) begin
                ni_din_q  <= s_data_i;
                ni_addr_q <= {cnt_q[NODE_INFO_ADDR_W-1:0], 2'b00};
            end
            if (w_wr) begin
                w_din_q  <= s_data_i;
                w_addr_q <= {cnt_q[WEIGHT_ADDR_W-1:0], 2'b00};
            end
        end
    end

    // Done flags trail the final write by one cycle so the BRAM has committed it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_pend_q  <= 1'b0;
            ni_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            h_done_q  <= 1'b0;
            ni_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (start_clr) begin
            h_pend_q  <= 1'b0;
            ni_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            h_done_q  <= 1'b0;
            ni_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            h_pend_q  <= h_pend_d;
            ni_pend_q <= ni_pend_d;
            w_pend_q  <= w_pend_d;
            h_done_q  <= h_done_q | h_pend_q;
            ni_done_q <= ni_done_q | ni_pend_q;
            w_done_q  <= w_done_q | w_pend_q;
            err_q     <= err_q | frame_err;
        end
    end

    assign h_data_bram_din_o        = h_din_q;
    assign h_data_bram_ena_o        = h_we_q;
    assign h_data_bram_wea_o        = h_we_q;
    assign h_data_bram_addra_o      = h_addr_q;
    assign h_node_info_bram_din_o   = ni_din_q;
    assign h_node_info_bram_ena_o   = ni_we_q;
    assign h_node_info_bram_wea_o   = ni_we_q;
    assign h_node_info_bram_addra_o = ni_addr_q;
    assign wgt_bram_din_o           = w_din_q;
    assign wgt_bram_ena_o           = w_we_q;
    assign wgt_bram_wea_o           = w_we_q;
    assign wgt_bram_addra_o         = w_addr_q;

    assign h_data_bram_load_done_o      = h_done_q;
    assign h_node_info_bram_load_done_o = ni_done_q;
    assign wgt_bram_load_done_o         = w_done_q;
    assign load_error_o                 = err_q;

endmodule
